tap_fsm_ctrl: RTL and testbench

//  IEEE 1149.1 TAP controller that sequences the bsc boundary-scan chain. It decodes TMS into the
//  16-state TAP FSM and holds the instruction register, bypass register and IDCODE register.
//  It drives ShiftDR/CaptureDR/UpdateDR/ClockDR/mode to every bsc cell and muxes TDO.

---
 rtl/tap_pkg.sv | 73 +++++++
 rtl/tap_ir_reg.sv | 71 +++++++
 rtl/tap_fsm_ctrl.sv | 144 ++++++++++++++
 tb/tb_tap_fsm_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings, instruction opcodes,
// IR capture pattern and the TMS-driven next-state rule.
package tap_pkg;

  typedef enum logic [3:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_e;

  localparam logic [3:0] OP_EXTEST = 4'b0000;
  localparam logic [3:0] OP_SAMPLE = 4'b0001;
  localparam logic [3:0] OP_IDCODE = 4'b0010;
  localparam logic [3:0] OP_BYPASS = 4'b1111;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  typedef enum logic [1:0] {
    DR_BSR    = 2'd0,
    DR_IDCODE = 2'd1,
    DR_BYPASS = 2'd2
  } dr_sel_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TAP_TLR:     n = tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:     n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR:   n = tms ? TAP_SELIR : TAP_CAPDR;
      TAP_SELIR:   n = tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPDR:   n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:    n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR:   n = tms ? TAP_UPDDR : TAP_PAUSEDR;
      TAP_PAUSEDR: n = tms ? TAP_EX2DR : TAP_PAUSEDR;
      TAP_EX2DR:   n = tms ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR:   n = tms ? TAP_SELDR : TAP_RTI;
      TAP_CAPIR:   n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:    n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR:   n = tms ? TAP_UPDIR : TAP_PAUSEIR;
      TAP_PAUSEIR: n = tms ? TAP_EX2IR : TAP_PAUSEIR;
      TAP_EX2IR:   n = tms ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR:   n = tms ? TAP_SELDR : TAP_RTI;
      default:     n = TAP_TLR;
    endcase
    return n;
  endfunction

  // Unlisted opcodes fall through to bypass.
  function automatic dr_sel_e dr_decode(input logic [3:0] op);
    dr_sel_e sel;
    case (op)
      OP_EXTEST, OP_SAMPLE: sel = DR_BSR;
      OP_IDCODE:            sel = DR_IDCODE;
      OP_BYPASS:            sel = DR_BYPASS;
      default:              sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/tap_ir_reg.sv
// Instruction register: capture/shift stage on posedge TCK, update stage and
// EXTEST mode flag on negedge TCK so the new instruction is stable for the next scan.
module tap_ir_reg
  import tap_pkg::*;
#(
  parameter int IR_WIDTH = 4
) (
  input  logic                tck_i,
  input  logic                trst_i,
  input  logic                tdi_i,
  input  logic                capture_i,
  input  logic                shift_i,
  input  logic                update_i,
  input  logic                tlr_i,
  output logic                shift_lsb_o,
  output logic [IR_WIDTH-1:0] ir_o,
  output logic                extest_o
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE_VAL  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_EXTEST_VAL  = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE_VAL = IR_WIDTH'(IR_CAPTURE);

  logic [IR_WIDTH-1:0] shift_q, shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                mode_q, mode_d;

  always_comb begin
    shift_d = shift_q;
    if (capture_i) begin
      shift_d = IR_CAPTURE_VAL;
    end else if (shift_i) begin
      shift_d = {tdi_i, shift_q[IR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  always_comb begin
    ir_d   = ir_q;
    mode_d = mode_q;
    if (tlr_i) begin
      ir_d   = IR_IDCODE_VAL;
      mode_d = 1'b0;
    end else if (update_i) begin
      ir_d   = shift_q;
      mode_d = (shift_q == IR_EXTEST_VAL);
    end
  end

  always_ff @(negedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      ir_q   <= IR_IDCODE_VAL;
      mode_q <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      mode_q <= mode_d;
    end
  end

  assign shift_lsb_o = shift_q[0];
  assign ir_o        = ir_q;
  assign extest_o    = mode_q;

endmodule

// File: rtl/tap_fsm_ctrl.sv
// IEEE 1149.1 TAP controller driving a boundary-scan chain: TAP FSM, IR,
// bypass/IDCODE data registers, bsc strobes, gated ClockDR and TDO mux.
//
// state           | meaning
// TLR             | test logic reset, IR reloads IDCODE
// RTI             | idle between scans
// SELDR / SELIR   | choose data or instruction scan
// CAPDR / CAPIR   | parallel load of the selected register
// SHDR / SHIR     | shift TDI toward TDO
// EX1x / EX2x     | leave shift or pause
// PAUSEDR/PAUSEIR | hold all shift registers
// UPDDR / UPDIR   | commit shifted value (IR on negedge)
module tap_fsm_ctrl
  import tap_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5A5F
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                bsr_so,
  output logic                TDO,
  output logic                TDO_EN,
  output logic                ShiftDR,
  output logic                CaptureDR,
  output logic                UpdateDR,
  output logic                ClockDR,
  output logic                mode,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_q
);

  tap_state_e  state_q, state_d;
  logic [31:0] id_shift_q, id_shift_d;
  logic        byp_q, byp_d;
  logic        tdo_q, tdo_d;
  logic        tdo_en_q, tdo_en_d;
  logic        clk_en_q, clk_en_d;
  logic        ir_lsb;
  logic [31:0] ir_ext;
  dr_sel_e     dr_sel;
  logic        bsr_sel;

  assign state_d = tap_next(state_q, TMS);

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q <= TAP_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  tap_ir_reg #(
    .IR_WIDTH(IR_WIDTH)
  ) u_ir (
    .tck_i      (TCK),
    .trst_i     (TRST),
    .tdi_i      (TDI),
    .capture_i  (state_q == TAP_CAPIR),
    .shift_i    (state_q == TAP_SHIR),
    .update_i   (state_q == TAP_UPDIR),
    .tlr_i      (state_q == TAP_TLR),
    .shift_lsb_o(ir_lsb),
    .ir_o       (ir_q),
    .extest_o   (mode)
  );

  // Codes wider than the defined opcode space can only be bypass.
  assign ir_ext  = 32'(ir_q);
  assign dr_sel  = (ir_ext[31:4] != '0) ? DR_BYPASS : dr_decode(ir_ext[3:0]);
  assign bsr_sel = (dr_sel == DR_BSR);

  always_comb begin
    id_shift_d = id_shift_q;
    byp_d      = byp_q;
    if (state_q == TAP_CAPDR) begin
      if (dr_sel == DR_IDCODE) id_shift_d = IDCODE_VAL;
      if (dr_sel == DR_BYPASS) byp_d = 1'b0;
    end else if (state_q == TAP_SHDR) begin
      if (dr_sel == DR_IDCODE) id_shift_d = {TDI, id_shift_q[31:1]};
      if (dr_sel == DR_BYPASS) byp_d = TDI;
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      id_shift_q <= IDCODE_VAL;
      byp_q      <= 1'b0;
    end else begin
      id_shift_q <= id_shift_d;
      byp_q      <= byp_d;
    end
  end

  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    case (state_q)
      TAP_SHIR: begin
        tdo_d    = ir_lsb;
        tdo_en_d = 1'b1;
      end
      TAP_SHDR: begin
        tdo_en_d = 1'b1;
        case (dr_sel)
          DR_BSR:    tdo_d = bsr_so;
          DR_IDCODE: tdo_d = id_shift_q[0];
          default:   tdo_d = byp_q;
        endcase
      end
      default: begin
        tdo_d    = 1'b0;
        tdo_en_d = 1'b0;
      end
    endcase
  end

  assign clk_en_d = bsr_sel && ((state_q == TAP_CAPDR) || (state_q == TAP_SHDR));

  // Negedge capture of the enable holds it through the whole high phase, so the AND is glitch-free.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign ClockDR   = TCK & clk_en_q;
  assign TDO       = tdo_q;
  assign TDO_EN    = tdo_en_q;
  assign ShiftDR   = (state_q == TAP_SHDR);
  assign CaptureDR = (state_q == TAP_CAPDR);
  assign UpdateDR  = (state_q == TAP_UPDDR) && bsr_sel;
  assign tap_state = state_q;

endmodule

// File: tb/tb_tap_fsm_ctrl.sv
// Bench for tap_fsm_ctrl: directed JTAG scans plus random TMS/TDI/TRST
// traffic against a cycle-level behavioural TAP model with a 4-cell bsc chain.
module tb_tap_fsm_ctrl;

  localparam logic [31:0] IDV = 32'h1234_5A5F;

  localparam int S_EX2DR = 0, S_EX1DR = 1, S_SHDR = 2, S_PAUSEDR = 3;
  localparam int S_SELIR = 4, S_UPDDR = 5, S_CAPDR = 6, S_SELDR = 7;
  localparam int S_EX2IR = 8, S_EX1IR = 9, S_SHIR = 10, S_PAUSEIR = 11;
  localparam int S_RTI = 12, S_UPDIR = 13, S_CAPIR = 14, S_TLR = 15;

  logic       TCK = 1'b0;
  logic       TRST = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       bsr_so;
  logic       TDO, TDO_EN, ShiftDR, CaptureDR, UpdateDR, ClockDR, mode;
  logic [3:0] tap_state;
  logic [3:0] ir_q;

  tap_fsm_ctrl #(.IR_WIDTH(4), .IDCODE_VAL(IDV)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .bsr_so(bsr_so),
    .TDO(TDO), .TDO_EN(TDO_EN), .ShiftDR(ShiftDR), .CaptureDR(CaptureDR),
    .UpdateDR(UpdateDR), .ClockDR(ClockDR), .mode(mode),
    .tap_state(tap_state), .ir_q(ir_q)
  );

  always #5 TCK = ~TCK;

  // 4-cell boundary-scan chain: cell0 fed by TDI, cell3 drives bsr_so
  logic [3:0] pi = 4'b1010;
  logic [3:0] env_bsr = 4'b0000;
  logic       env_shift = 1'b0;
  logic       env_cap = 1'b0;
  int         clkdr_cnt = 0;

  always @(negedge TCK) begin
    env_shift <= ShiftDR;
    env_cap   <= CaptureDR;
  end

  always @(posedge ClockDR) begin
    clkdr_cnt = clkdr_cnt + 1;
    if (env_shift) env_bsr <= {env_bsr[2:0], TDI};
    else if (env_cap) env_bsr <= pi;
  end

  assign bsr_so = env_bsr[3];

  int n_tests = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model
  int          nxt0[16];
  int          nxt1[16];
  int          m_state = S_TLR;
  logic [3:0]  m_ir = 4'b0010;
  logic [3:0]  m_irsh = 4'b0000;
  logic [31:0] m_id = IDV;
  logic        m_byp = 1'b0;
  logic [3:0]  m_bsr = 4'b0000;
  logic        m_mode = 1'b0;
  logic        m_tdo = 1'b0;
  logic        m_tdoen = 1'b0;
  int          m_clk = 0;
  int          cap_seen = 0;
  int          upd_seen = 0;

  task automatic set_tr(input int s, input int on0, input int on1);
    nxt0[s] = on0;
    nxt1[s] = on1;
  endtask

  // 0 = boundary scan, 1 = idcode, 2 = bypass
  function automatic int msel(input logic [3:0] ir);
    if (ir == 4'd0 || ir == 4'd1) return 0;
    if (ir == 4'd2) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_state = S_TLR; m_ir = 4'b0010; m_irsh = 4'b0000; m_id = IDV;
    m_byp = 1'b0; m_mode = 1'b0; m_tdo = 1'b0; m_tdoen = 1'b0;
  endtask

  task automatic model_pos(input logic tms, input logic tdi);
    int s;
    int sel;
    s = m_state;
    sel = msel(m_ir);
    if (s == S_CAPIR) m_irsh = 4'b0001;
    if (s == S_SHIR) m_irsh = (m_irsh >> 1) | (4'(tdi) << 3);
    if (s == S_CAPDR || s == S_SHDR) begin
      if (sel == 0) begin
        m_bsr = (s == S_CAPDR) ? pi : ((m_bsr << 1) | 4'(tdi));
        m_clk++;
      end else if (sel == 1) begin
        m_id = (s == S_CAPDR) ? IDV : ((m_id >> 1) | (32'(tdi) << 31));
      end else begin
        m_byp = (s == S_CAPDR) ? 1'b0 : tdi;
      end
    end
    m_state = tms ? nxt1[s] : nxt0[s];
  endtask

  task automatic model_neg();
    int sel;
    sel = msel(m_ir);
    m_tdoen = (m_state == S_SHIR) || (m_state == S_SHDR);
    if (m_state == S_SHIR) m_tdo = m_irsh[0];
    else if (m_state == S_SHDR) m_tdo = (sel == 0) ? m_bsr[3] : (sel == 1) ? m_id[0] : m_byp;
    else m_tdo = 1'b0;
    if (m_state == S_UPDIR) begin
      m_ir = m_irsh;
      m_mode = (m_irsh == 4'b0000);
    end else if (m_state == S_TLR) begin
      m_ir = 4'b0010;
      m_mode = 1'b0;
    end
  endtask

  task automatic check_all();
    check_eq("tap_state", 32'(tap_state), 32'(m_state));
    check_eq("ir_q", 32'(ir_q), 32'(m_ir));
    check_eq("TDO", 32'(TDO), 32'(m_tdo));
    check_eq("TDO_EN", 32'(TDO_EN), 32'(m_tdoen));
    check_eq("ShiftDR", 32'(ShiftDR), 32'(m_state == S_SHDR));
    check_eq("CaptureDR", 32'(CaptureDR), 32'(m_state == S_CAPDR));
    check_eq("UpdateDR", 32'(UpdateDR), 32'(m_state == S_UPDDR && msel(m_ir) == 0));
    check_eq("mode", 32'(mode), 32'(m_mode));
    check_eq("ClockDR_pulses", 32'(clkdr_cnt), 32'(m_clk));
  endtask

  task automatic cyc(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    model_pos(tms, tdi);
    @(negedge TCK);
    model_neg();
    #1;
    check_all();
    cap_seen += int'(CaptureDR);
    upd_seen += int'(UpdateDR);
  endtask

  task automatic do_trst();
    TRST = 1'b1;
    #1;
    model_reset();
    check_all();
    check_eq("trst_ClockDR", 32'(ClockDR), 32'd0);
    TRST = 1'b0;
    #1;
  endtask

  // Starts and ends in RTI; out[i] is the i-th bit seen on TDO.
  task automatic shift_ir(input logic [3:0] bits, output logic [3:0] out);
    out = 4'b0000;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    out[0] = TDO;
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3, bits[i]);
      if (i < 3) out[i+1] = TDO;
    end
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout,
                          output int pulses);
    int c0;
    dout = '0;
    cap_seen = 0;
    upd_seen = 0;
    c0 = clkdr_cnt;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    dout[0] = TDO;
    for (int i = 0; i < n; i++) begin
      cyc(i == n - 1, din[i]);
      if (i < n - 1) dout[i+1] = TDO;
    end
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    pulses = clkdr_cnt - c0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  o4;
    logic [31:0] dout;
    int          pulses;

    set_tr(S_TLR, S_RTI, S_TLR);       set_tr(S_RTI, S_RTI, S_SELDR);
    set_tr(S_SELDR, S_CAPDR, S_SELIR); set_tr(S_SELIR, S_CAPIR, S_TLR);
    set_tr(S_CAPDR, S_SHDR, S_EX1DR);  set_tr(S_SHDR, S_SHDR, S_EX1DR);
    set_tr(S_EX1DR, S_PAUSEDR, S_UPDDR); set_tr(S_PAUSEDR, S_PAUSEDR, S_EX2DR);
    set_tr(S_EX2DR, S_SHDR, S_UPDDR);  set_tr(S_UPDDR, S_RTI, S_SELDR);
    set_tr(S_CAPIR, S_SHIR, S_EX1IR);  set_tr(S_SHIR, S_SHIR, S_EX1IR);
    set_tr(S_EX1IR, S_PAUSEIR, S_UPDIR); set_tr(S_PAUSEIR, S_PAUSEIR, S_EX2IR);
    set_tr(S_EX2IR, S_SHIR, S_UPDIR);  set_tr(S_UPDIR, S_RTI, S_SELDR);

    #1 TRST = 1'b1;
    @(negedge TCK);
    #1;
    do_trst();

    // reset, then TMS=1 x5
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    check_eq("t1_state", 32'(tap_state), 32'hF);
    check_eq("t1_ir", 32'(ir_q), 32'b0010);
    check_eq("t1_tdo_en", 32'(TDO_EN), 32'd0);
    check_eq("t1_mode", 32'(mode), 32'd0);
    cyc(1'b0, 1'b0);

    // IDCODE readout
    shift_dr(32, $urandom, dout, pulses);
    check_eq("t3_idcode", dout, IDV);
    check_eq("t3_bit0", 32'(dout[0]), 32'd1);

    // BYPASS: TDI 1,0,1,1 -> TDO 0,1,0,1
    shift_ir(4'b1111, o4);
    check_eq("t4_ir", 32'(ir_q), 32'hF);
    shift_dr(4, 32'b1101, dout, pulses);
    check_eq("t4_bypass", 32'(dout[3:0]), 32'b1010);
    check_eq("t4_no_clockdr", 32'(pulses), 32'd0);

    // EXTEST load
    shift_ir(4'b0000, o4);
    check_eq("t2_capture", 32'(o4), 32'b0001);
    check_eq("t2_ir", 32'(ir_q), 32'b0000);
    check_eq("t2_mode", 32'(mode), 32'd1);

    // SAMPLE with PI=1010
    pi = 4'b1010;
    shift_ir(4'b0001, o4);
    check_eq("t5_mode_off", 32'(mode), 32'd0);
    shift_dr(4, 32'(4'($urandom)), dout, pulses);
    check_eq("t5_tdo", 32'(dout[3:0]), 32'b0101);
    check_eq("t5_capturedr", 32'(cap_seen), 32'd1);
    check_eq("t5_updatedr", 32'(upd_seen), 32'd1);
    check_eq("t5_clockdr", 32'(pulses), 32'd5);

    // TRST mid Shift-IR
    shift_ir(4'b1111, o4);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    do_trst();
    check_eq("t6_state", 32'(tap_state), 32'hF);
    check_eq("t6_ir", 32'(ir_q), 32'b0010);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    check_eq("t6_ir_hold", 32'(ir_q), 32'b0010);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      pi = 4'($urandom);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 79) == 0) do_trst();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
